// File: rtl/branch_resolve_queue_pkg.sv
// ---------------------------------------------------------------------------
// branch_resolve_queue_pkg
// Shared definitions for the branch resolve queue:
//   - direction encoding of the predictor state MSB (PRED_NT)
//   - FSM state encodings (ST_RUN, ST_RECOVER)
//   - entry layout {pred_nt, pc_plus1, target} and its width helpers
//   - mispredict decision helper
// No ports; imported by bq_fifo and branch_resolve_queue.
// ---------------------------------------------------------------------------
package branch_resolve_queue_pkg;

  // Predictor state MSB value meaning "predicted not taken".
  localparam logic PRED_NT = 1'b1;

  // FSM encodings.
  localparam logic [0:0] ST_RUN     = 1'b0;
  localparam logic [0:0] ST_RECOVER = 1'b1;

  // Entry width: one direction bit plus two program counters.
  function automatic int entry_width(input int pc_w);
    return 1 + 2 * pc_w;
  endfunction

  // Bit position of pred_nt inside an entry; pc_plus1 sits just below it,
  // target occupies the low PC_W bits.
  function automatic int pred_pos(input int pc_w);
    return 2 * pc_w;
  endfunction

  // A branch mispredicts when the predicted direction differs from the
  // resolved one. Predicted taken is the opposite of the PRED_NT encoding.
  function automatic logic is_mispredict(input logic pred_nt, input logic taken);
    logic pred_taken;
    pred_taken = (pred_nt != PRED_NT);
    return (pred_taken != taken);
  endfunction

endpackage

// File: rtl/bq_fifo.sv
// ---------------------------------------------------------------------------
// bq_fifo
// Circular-buffer storage for in-flight branch entries with pointers and an
// occupancy count. Pointers wrap modulo DEPTH (power of two). empty/full are
// registered alongside the count so they reflect the previous edge.
// Ports:
//   clk, rst        clock, asynchronous active-high reset
//   push, pop       write at wptr / advance rptr (caller guarantees legality)
//   clear           flush: pointers and count to zero, overrides push/pop
//   wdata           entry to write
//   rdata           entry at rptr (head), combinational read
//   empty, full     registered occupancy flags
// ---------------------------------------------------------------------------
module bq_fifo
  import branch_resolve_queue_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int W     = 33
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         push,
  input  logic         pop,
  input  logic         clear,
  input  logic [W-1:0] wdata,
  output logic [W-1:0] rdata,
  output logic         empty,
  output logic         full
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);
  localparam logic [PW-1:0] PTR_ONE  = PW'(1);
  localparam logic [PW-1:0] PTR_ZERO = PW'(0);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);
  localparam logic [CW-1:0] CNT_ZERO = CW'(0);
  localparam logic [CW-1:0] CNT_FULL = CW'(DEPTH);

  logic [W-1:0]  mem_r [DEPTH];
  logic [PW-1:0] wptr_r;
  logic [PW-1:0] rptr_r;
  logic [CW-1:0] count_r;
  logic          empty_r;
  logic          full_r;
  logic [PW-1:0] wptr_nxt_s;
  logic [PW-1:0] rptr_nxt_s;
  logic [CW-1:0] count_nxt_s;

  assign rdata = mem_r[rptr_r];
  assign empty = empty_r;
  assign full  = full_r;

  // Next-state computation for pointers and count.
  always_comb begin
    wptr_nxt_s  = wptr_r;
    rptr_nxt_s  = rptr_r;
    count_nxt_s = count_r;
    if (clear) begin
      wptr_nxt_s  = PTR_ZERO;
      rptr_nxt_s  = PTR_ZERO;
      count_nxt_s = CNT_ZERO;
    end else begin
      if (push) begin
        wptr_nxt_s = wptr_r + PTR_ONE;
      end else begin
        wptr_nxt_s = wptr_r;
      end
      if (pop) begin
        rptr_nxt_s = rptr_r + PTR_ONE;
      end else begin
        rptr_nxt_s = rptr_r;
      end
      case ({push, pop})
        2'b10:   count_nxt_s = count_r + CNT_ONE;
        2'b01:   count_nxt_s = count_r - CNT_ONE;
        default: count_nxt_s = count_r;
      endcase
    end
  end

  // Pointer, count and occupancy-flag registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wptr_r  <= PTR_ZERO;
      rptr_r  <= PTR_ZERO;
      count_r <= CNT_ZERO;
      empty_r <= 1'b1;
      full_r  <= 1'b0;
    end else begin
      wptr_r  <= wptr_nxt_s;
      rptr_r  <= rptr_nxt_s;
      count_r <= count_nxt_s;
      empty_r <= (count_nxt_s == CNT_ZERO);
      full_r  <= (count_nxt_s == CNT_FULL);
    end
  end

  // Entry storage; a push coinciding with a flush is discarded.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_r[i] <= {W{1'b0}};
      end
    end else if (push && !clear) begin
      mem_r[wptr_r] <= wdata;
    end
  end

endmodule

// File: rtl/branch_resolve_queue.sv
// ---------------------------------------------------------------------------
// branch_resolve_queue
// Tracks in-flight conditional branches between fetch and execute. On
// resolution it trains the predictor (upd_br/upd_taken) and, on a
// mispredict, redirects fetch and flushes the wrong-path entries.
// Ports:
//   clk, rst                       clock, asynchronous active-high reset
//   fetch_br, fetch_pred_nt,
//   fetch_pc_plus1, fetch_target   push request and entry fields
//   ex_valid, ex_taken             pop request and resolved direction
//   upd_br, upd_taken              registered predictor training pulse
//   mispredict, redirect_pc        registered redirect pulse and PC
//   empty, full                    occupancy (previous edge)
//   err                            sticky protocol-error flag
// ---------------------------------------------------------------------------
module branch_resolve_queue
  import branch_resolve_queue_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int PC_W  = 16
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            fetch_br,
  input  logic            fetch_pred_nt,
  input  logic [PC_W-1:0] fetch_pc_plus1,
  input  logic [PC_W-1:0] fetch_target,
  input  logic            ex_valid,
  input  logic            ex_taken,
  output logic            upd_br,
  output logic            upd_taken,
  output logic            mispredict,
  output logic [PC_W-1:0] redirect_pc,
  output logic            empty,
  output logic            full,
  output logic            err
);

  localparam int EW   = entry_width(PC_W);
  localparam int PPOS = pred_pos(PC_W);

  logic [0:0]      state_r;
  logic [0:0]      state_nxt_s;
  logic            upd_br_r;
  logic            upd_taken_r;
  logic            mispredict_r;
  logic [PC_W-1:0] redirect_pc_r;
  logic            err_r;

  logic [EW-1:0]   wdata_s;
  logic [EW-1:0]   rdata_s;
  logic            empty_s;
  logic            full_s;
  logic            head_pred_nt_s;
  logic [PC_W-1:0] head_pc_plus1_s;
  logic [PC_W-1:0] head_target_s;

  logic            run_s;
  logic            push_req_s;
  logic            pop_req_s;
  logic            pop_ok_s;
  logic            mis_s;
  logic            fifo_push_s;
  logic            fifo_pop_s;
  logic            err_set_s;
  logic [PC_W-1:0] redirect_nxt_s;

  assign wdata_s         = {fetch_pred_nt, fetch_pc_plus1, fetch_target};
  assign head_pred_nt_s  = rdata_s[PPOS];
  assign head_pc_plus1_s = rdata_s[PPOS-1 -: PC_W];
  assign head_target_s   = rdata_s[PC_W-1:0];

  bq_fifo #(
    .DEPTH (DEPTH),
    .W     (EW)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (fifo_push_s),
    .pop   (fifo_pop_s),
    .clear (mis_s),
    .wdata (wdata_s),
    .rdata (rdata_s),
    .empty (empty_s),
    .full  (full_s)
  );

  // Request qualification, resolve compare and error detection. In RECOVER
  // both requests are squashed, so neither can raise an error.
  always_comb begin
    run_s      = (state_r == ST_RUN);
    push_req_s = run_s & fetch_br;
    pop_req_s  = run_s & ex_valid;
    pop_ok_s   = pop_req_s & ~empty_s;
    mis_s      = pop_ok_s & is_mispredict(head_pred_nt_s, ex_taken);
    fifo_pop_s = pop_ok_s & ~mis_s;
    // A full queue still accepts a push when a correct pop frees the slot.
    fifo_push_s = push_req_s & ~mis_s & (~full_s | fifo_pop_s);
    // A push at full is an error only if no pop is draining the queue;
    // a mispredicting pop discards the push silently.
    err_set_s = (push_req_s & full_s & ~pop_ok_s) | (pop_req_s & empty_s);
    if (mis_s) begin
      redirect_nxt_s = ex_taken ? head_target_s : head_pc_plus1_s;
    end else begin
      redirect_nxt_s = {PC_W{1'b0}};
    end
  end

  // FSM next state: a mispredict costs exactly one RECOVER cycle.
  always_comb begin
    state_nxt_s = ST_RUN;
    case (state_r)
      ST_RUN: begin
        if (mis_s) begin
          state_nxt_s = ST_RECOVER;
        end else begin
          state_nxt_s = ST_RUN;
        end
      end
      ST_RECOVER: state_nxt_s = ST_RUN;
      default:    state_nxt_s = ST_RUN;
    endcase
  end

  // State, output pulse and sticky error registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r       <= ST_RUN;
      upd_br_r      <= 1'b0;
      upd_taken_r   <= 1'b0;
      mispredict_r  <= 1'b0;
      redirect_pc_r <= {PC_W{1'b0}};
      err_r         <= 1'b0;
    end else begin
      state_r       <= state_nxt_s;
      upd_br_r      <= pop_ok_s;
      upd_taken_r   <= pop_ok_s & ex_taken;
      mispredict_r  <= mis_s;
      redirect_pc_r <= redirect_nxt_s;
      err_r         <= err_r | err_set_s;
    end
  end

  assign upd_br      = upd_br_r;
  assign upd_taken   = upd_taken_r;
  assign mispredict  = mispredict_r;
  assign redirect_pc = redirect_pc_r;
  assign empty       = empty_s;
  assign full        = full_s;
  assign err         = err_r;

endmodule
